datapath_seq: RTL and testbench
===============================

DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 Parameter WIDTH, default 16, data width of registers, ALU and ports (WIDTH >= 4) SHALL be provided.
REQ-002 Parameter NREGS, default 8, register-file depth (power of two >= 2) SHALL be provided; RW = clog2(NREGS).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 datapath_in  in  WIDTH  external load data.
REQ-006 ext_write  in  1  external register write request; ext_writenum  in  RW  its target.
REQ-007 start  in  1  operation request, sampled in IDLE only.
REQ-008 rs_a, rs_b, rd  in  RW each  source A, source B, destination register.
REQ-009 shift  in  2  B shifter: 00 none, 01 left 1, 10 logical right 1, 11 arithmetic right 1.
REQ-010 ALUop  in  2  00 A+B, 01 A-B, 10 A&B, 11 ~B.
REQ-011 asel  in  1  1 forces ALU A input to zero; bsel  in  1  1 selects imm instead of shifted B.
REQ-012 imm  in  WIDTH  sign-extended immediate from the instruction decoder.
REQ-013 nowb  in  1  1 = compare-only: status updated, register file not written.
REQ-014 busy  out  1  high from accepted start until done; done  out  1  one-cycle completion pulse.
REQ-015 datapath_out  out  WIDTH  registered ALU result (C register).
REQ-016 N, V, Z  out  1 each  registered status: negative, signed overflow, zero.

Function
REQ-017 Operation fields (rs_a, rs_b, rd, shift, ALUop, asel, bsel, imm, nowb) SHALL be captured in a command register on the cycle start is accepted; later input changes SHALL NOT affect that operation.
REQ-018 FSM states SHALL be IDLE, LOADA, LOADB, EXEC, WB; IDLE -> LOADA on start, then one state per cycle, WB -> IDLE unconditionally.
REQ-019 LOADA: A <= R[rs_a]; LOADB: B <= R[rs_b]; EXEC: C and N/V/Z <= ALU result; WB: R[rd] <= C unless nowb, done = 1.
REQ-020 Latency: start high at edge k -> done high for exactly the cycle after edge k+4; busy high from edge k to edge k+5.
REQ-021 start while busy SHALL be ignored (no queueing).
REQ-022 ext_write SHALL write datapath_in to R[ext_writenum] only in IDLE; it SHALL be ignored while busy.
REQ-023 Simultaneous start and ext_write in IDLE: both accepted; LOADA/LOADB SHALL read the newly written value.
REQ-024 Arithmetic modulo 2^WIDTH; Z = (result == 0); N = result[WIDTH-1]; V = signed overflow for add/sub, 0 for AND/NOT.
REQ-025 datapath_out, N, V, Z SHALL hold their values between EXEC states.
REQ-026 Register file read combinational, write synchronous, one write port arbitrated per REQ-022/019.

Reset
REQ-027 rst_n low SHALL asynchronously force FSM to IDLE, busy = done = 0, A = B = C = 0, N = V = Z = 0, all registers 0, regardless of operation in progress.
REQ-028 An operation interrupted by reset SHALL NOT write the register file and SHALL NOT produce done.

Structure
REQ-029 ALUop and shift encodings and FSM state enum SHALL live in shared package datapath_pkg.
REQ-030 Register file SHALL be sub-module regfile (parameters WIDTH, NREGS); shifter and ALU inline.

Verification (WIDTH=16, NREGS=8)
REQ-031 ext_write R0=0x0001, R1=0x0002; start rs_a=1, rs_b=0, shift=01, ALUop=00, rd=2 -> done at k+5, datapath_out=0x0004, R2=0x0004, N=V=Z=0.
REQ-032 R3=0x7FFF; start rs_a=3, bsel=1, imm=0x0001, ALUop=00 -> datapath_out=0x8000, N=1, V=1, Z=0.
REQ-033 R4=0x1234, nowb=1, rs_a=4, rs_b=4, ALUop=01, rd=4 -> Z=1, datapath_out=0x0000, R4 still 0x1234.
REQ-034 start pulsed again and ext_write to R1 during busy -> no second done, R1 unchanged.
REQ-035 rst_n low during EXEC -> all outputs 0 immediately, no done, rd unchanged (0), next start works normally.
REQ-036 R5=0x8000, shift=11, ALUop=11, rs_b=5 -> datapath_out=0x3FFF (~0xC000), N=0.

Source files
------------

// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
//   Shared encodings for the sequential datapath:
//     alu_op_t - ALU operation select (ALUop port encoding)
//     shift_t  - B-operand shifter select (shift port encoding)
//     state_t  - controller FSM states
// -----------------------------------------------------------------------------
package datapath_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,   // A + B
        ALU_SUB = 2'b01,   // A - B
        ALU_AND = 2'b10,   // A & B
        ALU_NOT = 2'b11    // ~B
    } alu_op_t;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,   // pass through
        SH_LSL  = 2'b01,   // left by one
        SH_LSR  = 2'b10,   // logical right by one
        SH_ASR  = 2'b11    // arithmetic right by one
    } shift_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADA = 3'd1,
        S_LOADB = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4
    } state_t;

endpackage

// File: rtl/datapath_regfile.sv
// -----------------------------------------------------------------------------
// regfile
//   NREGS x WIDTH register file, one synchronous write port, one
//   combinational read port. All entries clear on asynchronous reset.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     we, waddr, wdata  write port (rising edge)
//     raddr, rdata      combinational read port
// -----------------------------------------------------------------------------
module regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [RW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [RW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/datapath_seq.sv
// -----------------------------------------------------------------------------
// datapath_seq
//   Multi-cycle register-file datapath: R[rd] <= ALU(A=R[rs_a], B=shift(R[rs_b]))
//   sequenced by a five-state controller (IDLE, LOADA, LOADB, EXEC, WB).
//
//   Handshake: start is accepted only when the block is idle (IDLE state and
//   busy low); the operation fields are captured on that edge. busy rises on
//   the accepting edge and stays high through the one-cycle done pulse, so
//   start and ext_write are ignored for the whole operation including the
//   done cycle. There is no queueing.
//
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     datapath_in, ext_write,
//     ext_writenum               external register load (idle only)
//     start, rs_a, rs_b, rd,
//     shift, ALUop, asel, bsel,
//     imm, nowb                  operation request and its fields
//     busy, done                 operation status
//     datapath_out, N, V, Z      registered ALU result and status flags
//     fsm_state                  controller state, for observation
// -----------------------------------------------------------------------------
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] datapath_in,
    input  logic             ext_write,
    input  logic [RW-1:0]    ext_writenum,
    input  logic             start,
    input  logic [RW-1:0]    rs_a,
    input  logic [RW-1:0]    rs_b,
    input  logic [RW-1:0]    rd,
    input  logic [1:0]       shift,
    input  logic [1:0]       ALUop,
    input  logic             asel,
    input  logic             bsel,
    input  logic [WIDTH-1:0] imm,
    input  logic             nowb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] datapath_out,
    output logic             N,
    output logic             V,
    output logic             Z,
    output state_t           fsm_state
);

    typedef struct packed {
        logic [RW-1:0]    rs_a;
        logic [RW-1:0]    rs_b;
        logic [RW-1:0]    rd;
        shift_t           shift;
        alu_op_t          aluop;
        logic             asel;
        logic             bsel;
        logic [WIDTH-1:0] imm;
        logic             nowb;
    } cmd_t;

    state_t           state_q, state_d;
    cmd_t             cmd_q;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic             n_q, v_q, z_q;
    logic             busy_q, done_q;

    logic             idle_free;
    logic             accept;
    logic             ext_we, wb_we, rf_we;
    logic [RW-1:0]    rf_waddr, rf_raddr;
    logic [WIDTH-1:0] rf_wdata, rf_rdata;

    logic [WIDTH-1:0] b_shift, a_in, b_in, alu_res;
    logic             alu_ovf;

    // busy stays high through the done cycle while the FSM is already back in
    // IDLE, so both conditions are needed to be truly free.
    assign idle_free = (state_q == S_IDLE) && !busy_q;
    assign accept    = idle_free && start;

    // Single write port: external loads only when free, write-back only in WB.
    // The two can never coincide because WB is not IDLE.
    assign ext_we   = idle_free && ext_write;
    assign wb_we    = (state_q == S_WB) && !cmd_q.nowb;
    assign rf_we    = ext_we || wb_we;
    assign rf_waddr = wb_we ? cmd_q.rd : ext_writenum;
    assign rf_wdata = wb_we ? c_q      : datapath_in;
    assign rf_raddr = (state_q == S_LOADA) ? cmd_q.rs_a : cmd_q.rs_b;

    regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    // B shifter
    always_comb begin
        b_shift = b_q;
        case (cmd_q.shift)
            SH_NONE: b_shift = b_q;
            SH_LSL:  b_shift = {b_q[WIDTH-2:0], 1'b0};
            SH_LSR:  b_shift = {1'b0, b_q[WIDTH-1:1]};
            SH_ASR:  b_shift = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
            default: b_shift = b_q;
        endcase
    end

    assign a_in = cmd_q.asel ? '0 : a_q;
    assign b_in = cmd_q.bsel ? cmd_q.imm : b_shift;

    // ALU: signed overflow when the result sign disagrees with what the
    // operand signs force (same-sign add, opposite-sign subtract).
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (cmd_q.aluop)
            ALU_ADD: begin
                alu_res = a_in + b_in;
                alu_ovf = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_in[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = a_in - b_in;
                alu_ovf = (a_in[WIDTH-1] != b_in[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_in[WIDTH-1]);
            end
            ALU_AND: alu_res = a_in & b_in;
            ALU_NOT: alu_res = ~b_in;
            default: alu_res = '0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_LOADA;
            S_LOADA: state_d = S_LOADB;
            S_LOADB: state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // done is registered so it lands one cycle after WB, when the
            // write-back is already visible in the register file.
            done_q  <= (state_q == S_WB);
            if (accept) begin
                cmd_q.rs_a  <= rs_a;
                cmd_q.rs_b  <= rs_b;
                cmd_q.rd    <= rd;
                cmd_q.shift <= shift_t'(shift);
                cmd_q.aluop <= alu_op_t'(ALUop);
                cmd_q.asel  <= asel;
                cmd_q.bsel  <= bsel;
                cmd_q.imm   <= imm;
                cmd_q.nowb  <= nowb;
                busy_q      <= 1'b1;
            end else if (done_q) begin
                busy_q      <= 1'b0;
            end
            if (state_q == S_LOADA) a_q <= rf_rdata;
            if (state_q == S_LOADB) b_q <= rf_rdata;
            if (state_q == S_EXEC) begin
                c_q <= alu_res;
                n_q <= alu_res[WIDTH-1];
                v_q <= alu_ovf;
                z_q <= (alu_res == '0);
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign datapath_out = c_q;
    assign N            = n_q;
    assign V            = v_q;
    assign Z            = z_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_datapath_seq.sv
// -----------------------------------------------------------------------------
// tb_datapath_seq
//   Directed bench for datapath_seq (WIDTH=16, NREGS=8). A register-array
//   model computes results from the arithmetic definition of each operation;
//   a negedge compare process checks busy/done/result/flags every cycle and
//   pops the expected result queue on each done pulse. Register contents are
//   observed by running compare-only pass-through operations (asel=1, B=R[n]).
// -----------------------------------------------------------------------------
module tb_datapath_seq;

    localparam int W   = 16;
    localparam int NR  = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [W-1:0] datapath_in = '0;
    logic         ext_write = 1'b0;
    logic [2:0]   ext_writenum = '0;
    logic         start = 1'b0;
    logic [2:0]   rs_a = '0, rs_b = '0, rd = '0;
    logic [1:0]   shift = '0, ALUop = '0;
    logic         asel = 1'b0, bsel = 1'b0, nowb = 1'b0;
    logic [W-1:0] imm = '0;
    logic         busy, done, N, V, Z;
    logic [W-1:0] datapath_out;
    logic [2:0]   fsm_state;

    datapath_seq #(.WIDTH(W), .NREGS(NR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .datapath_in  (datapath_in),
        .ext_write    (ext_write),
        .ext_writenum (ext_writenum),
        .start        (start),
        .rs_a         (rs_a),
        .rs_b         (rs_b),
        .rd           (rd),
        .shift        (shift),
        .ALUop        (ALUop),
        .asel         (asel),
        .bsel         (bsel),
        .imm          (imm),
        .nowb         (nowb),
        .busy         (busy),
        .done         (done),
        .datapath_out (datapath_out),
        .N            (N),
        .V            (V),
        .Z            (Z),
        .fsm_state    (fsm_state)
    );

    // ---------------- scoreboard / model state ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_regs [NR];
    logic         exp_busy = 1'b0, exp_done = 1'b0;
    logic [W-1:0] exp_out = '0;
    logic         exp_n = 1'b0, exp_v = 1'b0, exp_z = 1'b0;
    logic         chk_en = 1'b0;

    typedef struct {
        logic [2:0] rs_a, rs_b, rd;
        logic [1:0] shift, aluop;
        logic       asel, bsel, nowb;
        logic [W-1:0] imm;
    } op_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("datapath_out", datapath_out, exp_out);
            check("N", N, exp_n);
            check("V", V, exp_v);
            check("Z", Z, exp_z);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) check("done_without_op", 1, 0);
                else check("result_on_done", datapath_out, exp_q.pop_front());
            end
        end
    end

    // ---------------- model ----------------
    function automatic op_t mk_op(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                                  input logic [1:0] sh, input logic [1:0] op, input logic as,
                                  input logic bs, input logic [W-1:0] im, input logic nw);
        op_t o;
        o.rs_a = a; o.rs_b = b; o.rd = d; o.shift = sh; o.aluop = op;
        o.asel = as; o.bsel = bs; o.imm = im; o.nowb = nw;
        return o;
    endfunction

    // Pass-through read of R[idx] without writing anything back.
    function automatic op_t rd_op(input logic [2:0] idx);
        return mk_op(3'd0, idx, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, '0, 1'b1);
    endfunction

    function automatic void model_op(input op_t o, output logic [W-1:0] r,
                                     output logic n, output logic v, output logic z);
        int ua, ub, sa, sb, s;
        ub = int'(m_regs[o.rs_b]);
        case (o.shift)
            2'd1: ub = (ub * 2) % 65536;
            2'd2: ub = ub / 2;
            2'd3: ub = (ub / 2) + ((ub >= 32768) ? 32768 : 0);
            default: ;
        endcase
        if (o.bsel) ub = int'(o.imm);
        ua = o.asel ? 0 : int'(m_regs[o.rs_a]);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        v = 1'b0;
        case (o.aluop)
            2'd0: begin s = sa + sb; v = (s > 32767) || (s < -32768); r = 16'((ua + ub) % 65536); end
            2'd1: begin s = sa - sb; v = (s > 32767) || (s < -32768); r = 16'((ua - ub + 65536) % 65536); end
            2'd2: r = 16'(ua & ub);
            default: r = 16'(65535 - ub);
        endcase
        n = (r >= 16'h8000);
        z = (r == 16'h0000);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ext_wr(input logic [2:0] idx, input logic [W-1:0] val);
        ext_write = 1'b1; ext_writenum = idx; datapath_in = val;
        tick();
        ext_write = 1'b0;
        m_regs[idx] = val;
    endtask

    task automatic scramble();
        rs_a  = 3'($urandom_range(0, 7));
        rs_b  = 3'($urandom_range(0, 7));
        rd    = 3'($urandom_range(0, 7));
        shift = 2'($urandom_range(0, 3));
        ALUop = 2'($urandom_range(0, 3));
        asel  = 1'($urandom_range(0, 1));
        bsel  = 1'($urandom_range(0, 1));
        nowb  = 1'($urandom_range(0, 1));
        imm   = 16'($urandom_range(0, 65535));
    endtask

    task automatic run_op(input op_t o, input bit interfere, input bit rst_exec,
                          input bit sim_ext, input logic [2:0] ex_i, input logic [W-1:0] ex_v);
        logic [W-1:0] r;
        logic n, v, z;
        rs_a = o.rs_a; rs_b = o.rs_b; rd = o.rd; shift = o.shift; ALUop = o.aluop;
        asel = o.asel; bsel = o.bsel; imm = o.imm; nowb = o.nowb;
        start = 1'b1;
        if (sim_ext) begin ext_write = 1'b1; ext_writenum = ex_i; datapath_in = ex_v; end
        tick();                                 // edge k
        start = 1'b0; ext_write = 1'b0;
        if (sim_ext) m_regs[ex_i] = ex_v;
        model_op(o, r, n, v, z);
        exp_q.push_back(r);
        exp_busy = 1'b1;
        scramble();
        if (interfere) begin
            start = 1'b1; ext_write = 1'b1; ext_writenum = 3'd1; datapath_in = 16'hDEAD;
        end
        tick();                                 // edge k+1
        tick();                                 // edge k+2
        if (rst_exec) begin
            rst_n = 1'b0;
            #1;
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_out", datapath_out, 0);
            check("rst_nvz", {N, V, Z}, 0);
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            exp_busy = 0; exp_done = 0; exp_out = '0; exp_n = 0; exp_v = 0; exp_z = 0;
            void'(exp_q.pop_back());
            #2;
            rst_n = 1'b1;
            return;
        end
        tick();                                 // edge k+3
        exp_out = r; exp_n = n; exp_v = v; exp_z = z;
        tick();                                 // edge k+4
        exp_done = 1'b1;
        if (!o.nowb) m_regs[o.rd] = r;
        tick();                                 // edge k+5
        exp_done = 1'b0; exp_busy = 1'b0;
        start = 1'b0; ext_write = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [2:0] idx, input logic [W-1:0] lit);
        run_op(rd_op(idx), 0, 0, 0, 3'd0, '0);
        check(name, datapath_out, lit);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out", datapath_out, 0);
        check("reset_nvz", {N, V, Z}, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();
        read_check("reset_r7", 3'd7, 16'h0000);

        // R1 + (R0 << 1) -> R2
        ext_wr(3'd0, 16'h0001);
        ext_wr(3'd1, 16'h0002);
        run_op(mk_op(3'd1, 3'd0, 3'd2, 2'b01, 2'b00, 0, 0, '0, 0), 0, 0, 0, 3'd0, '0);
        check("add_shl_out", datapath_out, 16'h0004);
        check("add_shl_model", exp_out, 16'h0004);
        check("add_shl_nvz", {N, V, Z}, 3'b000);
        read_check("add_shl_r2", 3'd2, 16'h0004);

        // 0x7FFF + imm 1: signed overflow into negative
        ext_wr(3'd3, 16'h7FFF);
        run_op(mk_op(3'd3, 3'd0, 3'd6, 2'b00, 2'b00, 0, 1, 16'h0001, 0), 0, 0, 0, 3'd0, '0);
        check("add_ovf_out", datapath_out, 16'h8000);
        check("add_ovf_nvz", {N, V, Z}, 3'b110);
        check("add_ovf_model", {exp_n, exp_v, exp_z}, 3'b110);

        // compare-only subtract of equal values
        ext_wr(3'd4, 16'h1234);
        run_op(mk_op(3'd4, 3'd4, 3'd4, 2'b00, 2'b01, 0, 0, '0, 1), 0, 0, 0, 3'd0, '0);
        check("cmp_out", datapath_out, 16'h0000);
        check("cmp_nvz", {N, V, Z}, 3'b001);
        read_check("cmp_r4_kept", 3'd4, 16'h1234);

        // start and ext_write held high throughout the busy period
        run_op(mk_op(3'd0, 3'd1, 3'd7, 2'b00, 2'b00, 0, 0, '0, 0), 1, 0, 0, 3'd0, '0);
        check("busy_ignore_out", datapath_out, 16'h0003);
        tick();
        tick();
        read_check("busy_ignore_r1", 3'd1, 16'h0002);

        // start together with ext_write: LOADA/LOADB see the new value
        run_op(mk_op(3'd6, 3'd6, 3'd5, 2'b00, 2'b00, 0, 0, '0, 0), 0, 0, 1, 3'd6, 16'h0100);
        check("sim_ext_out", datapath_out, 16'h0200);
        read_check("sim_ext_r5", 3'd5, 16'h0200);

        // signed overflow on subtract, then AND with logical right shift
        ext_wr(3'd0, 16'h8000);
        ext_wr(3'd7, 16'h0001);
        run_op(mk_op(3'd0, 3'd7, 3'd2, 2'b00, 2'b01, 0, 0, '0, 0), 0, 0, 0, 3'd0, '0);
        check("sub_ovf_out", datapath_out, 16'h7FFF);
        check("sub_ovf_nvz", {N, V, Z}, 3'b010);
        ext_wr(3'd3, 16'h00F3);
        run_op(mk_op(3'd3, 3'd3, 3'd4, 2'b10, 2'b10, 0, 0, '0, 0), 0, 0, 0, 3'd0, '0);
        check("and_lsr_out", datapath_out, 16'h0071);

        // reset during EXEC: no done, no write-back
        run_op(mk_op(3'd3, 3'd3, 3'd1, 2'b00, 2'b00, 0, 0, '0, 0), 0, 1, 0, 3'd0, '0);
        tick();
        read_check("rst_exec_rd", 3'd1, 16'h0000);

        // NOT of arithmetic-right-shifted 0x8000
        ext_wr(3'd5, 16'h8000);
        run_op(mk_op(3'd0, 3'd5, 3'd6, 2'b11, 2'b11, 0, 0, '0, 0), 0, 0, 0, 3'd0, '0);
        check("not_asr_out", datapath_out, 16'h3FFF);
        check("not_asr_nvz", {N, V, Z}, 3'b000);
        read_check("not_asr_r6", 3'd6, 16'h3FFF);

        tick();
        chk_en = 1'b0;
        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
